// File: rtl/demux1to32_collector_pkg.sv
// Shared defaults and state encoding for the 1-to-32 serial bit collector.
package demux1to32_collector_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned SELW_DEF  = $clog2(WIDTH_DEF);

  typedef enum logic {
    StFill = 1'b0,
    StDone = 1'b1
  } state_e;

endpackage

// File: rtl/demux1to32_collector_dec_lane_onehot.sv
// Combinational lane-address to one-hot decoder; forms the accumulator write enable.
module demux1to32_collector_dec_lane_onehot #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = $clog2(WIDTH)
) (
  input  logic [SELW-1:0]  lane,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[lane] = 1'b1;
  end

endmodule

// File: rtl/demux1to32_collector.sv
// Steers serial bits into an addressed or auto-indexed lane of an accumulator and
// hands completed words to a single-entry valid/ready output slot.
module demux1to32_collector
  import demux1to32_collector_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SELW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic             din,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SELW-1:0]  fill_idx
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [SELW-1:0]  idx_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic [SELW-1:0]  lane;
  logic [WIDTH-1:0] lane_oh;
  logic             accept;
  logic             slot_free;
  logic             frame_end;
  logic             transfer;

  assign lane = mode ? idx_q : sel;

  demux1to32_collector_dec_lane_onehot #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_dec (
    .lane   (lane),
    .onehot (lane_oh)
  );

  // in_ready depends on state only, so out_ready never reaches the input side.
  assign in_ready  = (state_q == StFill);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign frame_end = in_last || (mode && (idx_q == SELW'(WIDTH - 1)));
  assign transfer  = (state_q == StDone) && slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StFill: begin
          if (accept) begin
            acc_q <= din ? (acc_q | lane_oh) : (acc_q & ~lane_oh);
            if (mode) begin
              idx_q <= idx_q + SELW'(1);
            end
            if (frame_end) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (slot_free) begin
            out_data_q <= acc_q;
            acc_q      <= '0;
            idx_q      <= '0;
            state_q    <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase

      // A new word landing on the consuming edge keeps the slot full.
      if (transfer) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign fill_idx  = idx_q;

endmodule

// File: doc/demux1to32_collector.md
Name: demux1to32_collector

Overview:
Sequential 1-to-32 demultiplexer/collector, the write-side counterpart of the 32:1 bit-select mux. It steers a serial input bit into an addressed or auto-indexed position of a 32-bit accumulation register. It then presents the completed word on a valid/ready output port. It sits between a bit-serial producer and any consumer of parallel words, and closes the loop with the 32:1 mux for parallel-to-serial-to-parallel round trips.

Parameters:
WIDTH, 32, number of output bit lanes; must be a power of two, minimum 2.
SELW, $clog2(WIDTH) = 5, width of the lane address.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
mode  input  1  0 = addressed (bit goes to lane sel), 1 = sequential (bit goes to lane given by internal index); sampled per accepted beat.
sel  input  SELW  lane address; used only when mode=0.
din  input  1  serial data bit.
in_valid  input  1  beat offered.
in_last  input  1  beat is final of frame; qualified by handshake.
in_ready  output  1  collector can accept a beat.
out_data  output  WIDTH  completed word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts out_data.
fill_idx  output  SELW  current sequential index (debug/status).

Behaviour:
- Reset (async assert, removal synchronous to clk): acc=0, idx=0, state=FILL, out_data=0, out_valid=0, fill_idx=0. in_ready goes 1 once reset is released.
- Beat accepted when in_valid && in_ready at a rising edge.
- States:
  - FILL: in_ready=1.
  - DONE: in_ready=0; acc holds a complete frame.
- FILL, accepted beat, mode=0: acc[sel] <= din; idx unchanged.
- FILL, accepted beat, mode=1: acc[idx] <= din; idx <= idx+1, wrapping WIDTH-1 -> 0.
- Frame end, go to DONE, on either:
  - an accepted beat with in_last=1 (either mode), or
  - an accepted mode=1 beat with idx=WIDTH-1.
- Repeated mode=0 writes to the same lane: the last write wins.
- Lanes never written in a frame read 0.
- DONE -> FILL when the output slot is free (out_valid=0, or out_ready=1 this cycle). On that edge:
  - out_data <= acc, out_valid <= 1.
  - acc <= 0, idx <= 0.
- Latency: last beat accepted at edge k produces out_valid=1 after edge k+1 if the slot is free. Otherwise the frame stays in DONE until the slot frees. Sustained throughput is one frame per (beats+1) cycles.
- Output handshake: out_valid && out_ready at an edge consumes the word. If DONE transfers on the same edge, out_valid stays 1 with the new data. Otherwise out_valid <= 0; out_data holds its stale value.
- out_data and out_valid are stable while out_valid=1 && out_ready=0.
- Mixed modes within one frame are legal; only mode=1 beats advance idx.
- in_valid=0 or in_ready=0: no state change in acc or idx.
- Reset mid-frame: the partial frame and any pending output are discarded.
- All outputs are registered except in_ready, which is decoded from state only (no combinational path from out_ready).

Decomposition:
- Shared package: WIDTH/SELW defaults; state encoding FILL=1'b0, DONE=1'b1.
- Natural sub-module: dec_lane_onehot, a combinational SELW-to-WIDTH one-hot lane decoder (demux). It is used to form the acc write enable from the chosen index (sel or idx).
- Output register slot kept inline.

Test Plan:
1. Sequential fill: mode=1, 32 beats with din = bit i of 32'hA5C3_0F96, out_ready=1 -> out_data=32'hA5C3_0F96, out_valid high one cycle, arriving one edge after the 32nd beat; fill_idx returns to 0.
2. Addressed sparse frame: mode=0, beats (sel=3,din=1), (sel=31,din=1), (sel=3,din=0), then (sel=0,din=1,in_last=1) -> out_data=32'h8000_0001.
3. Backpressure: out_ready=0, complete two frames 32'h0000_FFFF then 32'hFFFF_0000 -> first word held stable; in_ready=0 after the second frame ends. Raise out_ready for one cycle -> second word appears the same edge the first is consumed; in_ready returns to 1.
4. Early in_last in mode=1 after 5 beats of 1 -> out_data=32'h0000_001F; next frame starts at idx=0.
5. Async reset asserted mid-frame (after 10 beats) and while out_valid=1 -> out_valid=0, out_data=0, fill_idx=0 immediately without a clock edge; the next full frame is correct.
6. Round trip: feed the collected out_data into the 32:1 mux and sweep sel 0..31 -> the mux output matches the original din sequence bit for bit.
